// File: rtl/mdu_iter.sv
// mdu_iter: handshaked multiply/divide unit with HI/LO, pipelined multiply and radix-2 restoring divide
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, dvs, abs1, abs2;
  logic [WIDTH:0] shifted, diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] pipe [MUL_STAGES];
  logic q_neg, r_neg, accept, is_mul, is_div, sgn, dz, last_mul;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign accept    = req_valid && req_ready && !cancel;
  assign is_mul    = req_op[2:1] == 2'b00;
  assign is_div    = req_op[2:1] == 2'b01;
  assign sgn       = !req_op[0];
  assign dz        = req_src2 == '0;
  assign abs1      = (sgn && req_src1[WIDTH-1]) ? -req_src1 : req_src1;
  assign abs2      = (sgn && req_src2[WIDTH-1]) ? -req_src2 : req_src2;
  assign prod      = {{WIDTH{sgn & req_src1[WIDTH-1]}}, req_src1} * {{WIDTH{sgn & req_src2[WIDTH-1]}}, req_src2};
  assign shifted   = {rem, quot[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign last_mul  = state == MUL && cnt == CW'(MUL_STAGES - 1);
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state: cancel wins over everything once an operation is in flight
  always_comb begin
    nxt = state;
    if (cancel && state != IDLE) nxt = IDLE;
    else if (accept && is_mul) nxt = MUL;
    else if (accept && is_div) nxt = DIV;
    else if (last_mul || state == FIX) nxt = IDLE;
    else if (state == DIV && cnt == '0) nxt = FIX;
  end
  // datapath: product pipeline, divider iteration, HI/LO commits
  always_ff @(posedge clk)
    if (reset) begin
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      done <= (last_mul || state == FIX) && !cancel;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
      if (state == MUL) cnt <= cnt + 1'b1;
      if (state == DIV) begin
        rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], !diff[WIDTH]};
        cnt <= cnt - 1'b1;
      end
      if (accept && is_mul) begin
        pipe[0] <= prod;
        cnt <= '0;
      end
      if (accept && is_div) begin
        quot <= dz ? req_src1 : abs1;
        dvs <= abs2;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
        q_neg <= sgn && !dz && (req_src1[WIDTH-1] ^ req_src2[WIDTH-1]);
        r_neg <= sgn && !dz && req_src1[WIDTH-1];
      end
      if (accept && req_op == 3'b100) hi <= req_src1;
      if (accept && req_op == 3'b101) lo <= req_src1;
      if (last_mul && !cancel) {hi, lo} <= pipe[MUL_STAGES-1];
      if (state == FIX && !cancel) begin
        hi <= r_neg ? -rem : rem;
        lo <= q_neg ? -quot : quot;
      end
    end
endmodule
